// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 255;

    // ID instruction reads a register that the load in EX has not yet delivered.
    function automatic logic hz_load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used,
        input logic [4:0] rd,
        input logic       reg_write,
        input logic       is_load
    );
        return is_load & reg_write & (rd != 5'd0) &
               ((rs1_used & (rs1 == rd)) | (rs2_used & (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait freezes with a sticky timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; a pending memory access stalls for one cycle here
// MEM_WAIT | pipeline frozen waiting on mem_ready; wait_cnt counts the wait
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [4:0]  rd_EX,
    input  logic        RegWrite_EX,
    input  logic        DatatoReg_EX,
    input  logic        branch_taken_EX,
    input  logic        mem_req_MEM,
    input  logic        mem_ready,
    output logic        en_PC,
    output logic        en_IFID,
    output logic        en_IDEX,
    output logic        en_EXMEM,
    output logic        en_MEMWB,
    output logic        flush_IFID,
    output logic        flush_IDEX,
    output logic        flush_MEMWB,
    output logic        pc_redirect,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    hz_state_t  state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       load_use;
    logic       mem_stall;

    assign wait_nxt = wait_cnt + 8'd1;

    always_comb begin
        load_use  = hz_load_use(rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
                                rd_EX, RegWrite_EX, DatatoReg_EX);
        mem_stall = mem_req_MEM & ~mem_ready & ~mem_err;

        en_PC       = 1'b1;
        en_IFID     = 1'b1;
        en_IDEX     = 1'b1;
        en_EXMEM    = 1'b1;
        en_MEMWB    = 1'b1;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        flush_MEMWB = 1'b0;
        pc_redirect = 1'b0;

        // A branch in EX is frozen with the rest of the front end during a
        // memory wait and redirects once the wait releases.
        if (mem_stall) begin
            en_PC       = 1'b0;
            en_IFID     = 1'b0;
            en_IDEX     = 1'b0;
            en_EXMEM    = 1'b0;
            flush_MEMWB = 1'b1;
        end else if (branch_taken_EX) begin
            pc_redirect = 1'b1;
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
        end else if (load_use) begin
            en_PC      = 1'b0;
            en_IFID    = 1'b0;
            flush_IDEX = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            if (!en_PC && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;

            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    wait_cnt <= wait_nxt;
                    if (mem_ready || mem_err || !mem_req_MEM) begin
                        state <= RUN;
                    end else if (wait_nxt == TIMEOUT_CNT) begin
                        // wait_cnt reaches MEM_TIMEOUT on this edge
                        mem_err <= 1'b1;
                        state   <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
